// File: rtl/mem_arbiter_if.sv
// Bus bundle between the CPU data port, the auxiliary requester, the arbiter and the SRAM pins.
// The slave modport is the arbiter's view; the master modport is the view of the requesters and the SRAM.
interface mem_arbiter_if;
    logic        cpu_rd;
    logic        cpu_wr;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic [15:0] cpu_rdata;
    logic        cpu_busy;
    logic        cpu_ready;

    logic        aux_req;
    logic        aux_we;
    logic [15:0] aux_addr;
    logic [15:0] aux_wdata;
    logic [15:0] aux_rdata;
    logic        aux_ack;

    logic [15:0] m_addr;
    logic [15:0] m_wdata;
    logic [15:0] m_rdata;
    logic        m_ce;
    logic        m_oe;
    logic        m_we;

    modport slave (
        input  cpu_rd,
        input  cpu_wr,
        input  cpu_addr,
        input  cpu_wdata,
        output cpu_rdata,
        output cpu_busy,
        output cpu_ready,
        input  aux_req,
        input  aux_we,
        input  aux_addr,
        input  aux_wdata,
        output aux_rdata,
        output aux_ack,
        output m_addr,
        output m_wdata,
        input  m_rdata,
        output m_ce,
        output m_oe,
        output m_we
    );

    modport master (
        output cpu_rd,
        output cpu_wr,
        output cpu_addr,
        output cpu_wdata,
        input  cpu_rdata,
        input  cpu_busy,
        input  cpu_ready,
        output aux_req,
        output aux_we,
        output aux_addr,
        output aux_wdata,
        input  aux_rdata,
        input  aux_ack,
        input  m_addr,
        input  m_wdata,
        output m_rdata,
        input  m_ce,
        input  m_oe,
        input  m_we
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between the CPU data port and an auxiliary port.
// Every access is IDLE -> ACCESS (WAIT_CYCLES cycles) -> DONE, with all outputs registered.
module mem_arbiter #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic        r_grant_cpu;
    logic        r_last_cpu;
    logic        r_op_wr;
    logic        r_cpu_armed;
    logic        r_aux_armed;
    logic [15:0] r_m_addr;
    logic [15:0] r_m_wdata;
    logic [15:0] r_cpu_rdata;
    logic [15:0] r_aux_rdata;
    logic        r_busy;
    logic        r_ready;
    logic        r_ack;
    logic        r_ce;
    logic        r_oe;
    logic        r_we;

    logic        w_cpu_req;
    logic        w_cpu_vld;
    logic        w_aux_vld;
    logic        w_grant;
    logic        w_pick_cpu;
    logic        w_op_wr_nxt;
    logic        w_last_beat;
    logic        w_read_capture;

    // Request qualification, round-robin grant and next-state selection.
    always_comb begin
        w_cpu_req      = bus.cpu_rd | bus.cpu_wr;
        w_cpu_vld      = w_cpu_req & r_cpu_armed;
        w_aux_vld      = bus.aux_req & r_aux_armed;
        w_grant        = 1'b0;
        w_pick_cpu     = 1'b0;
        w_op_wr_nxt    = r_op_wr;
        w_state_nxt    = r_state;
        w_last_beat    = (r_state == ACCESS) && (r_cnt == 4'd0);
        w_read_capture = w_last_beat && !r_op_wr;

        case (r_state)
            IDLE: begin
                if (w_cpu_vld || w_aux_vld) begin
                    w_grant     = 1'b1;
                    // On a tie the port that did not win last time goes first.
                    w_pick_cpu  = w_cpu_vld && (!w_aux_vld || !r_last_cpu);
                    w_op_wr_nxt = w_pick_cpu ? bus.cpu_wr : bus.aux_we;
                    w_state_nxt = ACCESS;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            ACCESS: begin
                if (w_last_beat) begin
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt = ACCESS;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State register plus strobes registered from the next state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_ce    <= 1'b0;
            r_oe    <= 1'b0;
            r_we    <= 1'b0;
            r_ready <= 1'b0;
            r_ack   <= 1'b0;
            r_op_wr <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != IDLE);
            r_ce    <= (w_state_nxt == ACCESS);
            r_oe    <= (w_state_nxt == ACCESS) && !w_op_wr_nxt;
            r_we    <= (w_state_nxt == ACCESS) && w_op_wr_nxt;
            r_ready <= (w_state_nxt == DONE) && r_grant_cpu;
            r_ack   <= (w_state_nxt == DONE) && !r_grant_cpu;
            r_op_wr <= w_op_wr_nxt;
        end
    end

    // Grant bookkeeping, address/data latch and wait-state counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_grant_cpu <= 1'b0;
            r_last_cpu  <= 1'b0;
            r_cnt       <= 4'd0;
            r_m_addr    <= 16'h0000;
            r_m_wdata   <= 16'h0000;
        end else if (w_grant) begin
            r_grant_cpu <= w_pick_cpu;
            r_last_cpu  <= w_pick_cpu;
            r_cnt       <= CNT_INIT;
            r_m_addr    <= w_pick_cpu ? bus.cpu_addr  : bus.aux_addr;
            r_m_wdata   <= w_pick_cpu ? bus.cpu_wdata : bus.aux_wdata;
        end else if ((r_state == ACCESS) && (r_cnt != 4'd0)) begin
            r_cnt       <= r_cnt - 4'd1;
        end else begin
            r_cnt       <= r_cnt;
        end
    end

    // Read data capture on the final access beat, granted port only.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cpu_rdata <= 16'h0000;
            r_aux_rdata <= 16'h0000;
        end else if (w_read_capture && r_grant_cpu) begin
            r_cpu_rdata <= bus.m_rdata;
        end else if (w_read_capture && !r_grant_cpu) begin
            r_aux_rdata <= bus.m_rdata;
        end else begin
            r_cpu_rdata <= r_cpu_rdata;
            r_aux_rdata <= r_aux_rdata;
        end
    end

    // A port re-arms only after its request is seen low, so a held request is served once.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cpu_armed <= 1'b1;
            r_aux_armed <= 1'b1;
        end else begin
            if ((r_state == DONE) && r_grant_cpu) begin
                r_cpu_armed <= 1'b0;
            end else if (!w_cpu_req) begin
                r_cpu_armed <= 1'b1;
            end else begin
                r_cpu_armed <= r_cpu_armed;
            end

            if ((r_state == DONE) && !r_grant_cpu) begin
                r_aux_armed <= 1'b0;
            end else if (!bus.aux_req) begin
                r_aux_armed <= 1'b1;
            end else begin
                r_aux_armed <= r_aux_armed;
            end
        end
    end

    assign bus.cpu_rdata = r_cpu_rdata;
    assign bus.cpu_busy  = r_busy;
    assign bus.cpu_ready = r_ready;
    assign bus.aux_rdata = r_aux_rdata;
    assign bus.aux_ack   = r_ack;
    assign bus.m_addr    = r_m_addr;
    assign bus.m_wdata   = r_m_wdata;
    assign bus.m_ce      = r_ce;
    assign bus.m_oe      = r_oe;
    assign bus.m_we      = r_we;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one DUT with WAIT_CYCLES=2 and a second with WAIT_CYCLES=1.
// Outputs are sampled 1 time unit after each rising edge.
module tb_mem_arbiter;

    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;

    mem_arbiter_if bus  ();
    mem_arbiter_if bus1 ();

    mem_arbiter #(.WAIT_CYCLES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    mem_arbiter #(.WAIT_CYCLES(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    // {m_ce, m_oe, m_we, cpu_busy, cpu_ready, aux_ack}
    logic [5:0] ctl;
    logic [5:0] ctl1;
    assign ctl  = {bus.m_ce,  bus.m_oe,  bus.m_we,  bus.cpu_busy,  bus.cpu_ready,  bus.aux_ack};
    assign ctl1 = {bus1.m_ce, bus1.m_oe, bus1.m_we, bus1.cpu_busy, bus1.cpu_ready, bus1.aux_ack};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        n_total++; if (ctl !== 6'b000000) $display("FAIL reset_ctl got %b exp %b", ctl, 6'b000000); else n_pass++;
        n_total++; if (ctl1 !== 6'b000000) $display("FAIL reset_ctl1 got %b exp %b", ctl1, 6'b000000); else n_pass++;
        n_total++; if (bus.m_addr !== 16'h0000) $display("FAIL reset_m_addr got %h exp %h", bus.m_addr, 16'h0000); else n_pass++;
        n_total++; if (bus.m_wdata !== 16'h0000) $display("FAIL reset_m_wdata got %h exp %h", bus.m_wdata, 16'h0000); else n_pass++;
        n_total++; if (bus.cpu_rdata !== 16'h0000) $display("FAIL reset_cpu_rdata got %h exp %h", bus.cpu_rdata, 16'h0000); else n_pass++;
        n_total++; if (bus.aux_rdata !== 16'h0000) $display("FAIL reset_aux_rdata got %h exp %h", bus.aux_rdata, 16'h0000); else n_pass++;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_cpu_read();
        logic [5:0] exp_ctl [4];
        exp_ctl = '{6'b110100, 6'b110100, 6'b000110, 6'b000000};
        bus.cpu_addr = 16'h1234;
        bus.m_rdata  = 16'hBEEF;
        bus.cpu_rd   = 1'b1;
        tick();
        // address changes after the grant edge must be ignored
        bus.cpu_rd   = 1'b0;
        bus.cpu_addr = 16'hFFFF;
        for (int i = 0; i < 4; i++) begin
            n_total++; if (ctl !== exp_ctl[i]) $display("FAIL rd_ctl cyc%0d got %b exp %b", i, ctl, exp_ctl[i]); else n_pass++;
            if (i < 2) begin
                n_total++; if (bus.m_addr !== 16'h1234) $display("FAIL rd_m_addr cyc%0d got %h exp %h", i, bus.m_addr, 16'h1234); else n_pass++;
            end
            if (i == 2) begin
                n_total++; if (bus.cpu_rdata !== 16'hBEEF) $display("FAIL rd_cpu_rdata got %h exp %h", bus.cpu_rdata, 16'hBEEF); else n_pass++;
            end
            tick();
        end
    endtask

    task automatic test_cpu_write();
        logic [5:0] exp_ctl [4];
        exp_ctl = '{6'b101100, 6'b101100, 6'b000110, 6'b000000};
        bus.cpu_addr  = 16'h0010;
        bus.cpu_wdata = 16'h00AA;
        bus.m_rdata   = 16'h5555;
        bus.cpu_wr    = 1'b1;
        tick();
        bus.cpu_wr    = 1'b0;
        bus.cpu_wdata = 16'h1111;
        for (int i = 0; i < 4; i++) begin
            n_total++; if (ctl !== exp_ctl[i]) $display("FAIL wr_ctl cyc%0d got %b exp %b", i, ctl, exp_ctl[i]); else n_pass++;
            if (i < 2) begin
                n_total++; if (bus.m_wdata !== 16'h00AA) $display("FAIL wr_m_wdata cyc%0d got %h exp %h", i, bus.m_wdata, 16'h00AA); else n_pass++;
                n_total++; if (bus.m_addr !== 16'h0010) $display("FAIL wr_m_addr cyc%0d got %h exp %h", i, bus.m_addr, 16'h0010); else n_pass++;
            end else begin
                n_total++; if (bus.cpu_rdata !== 16'hBEEF) $display("FAIL wr_cpu_rdata cyc%0d got %h exp %h", i, bus.cpu_rdata, 16'hBEEF); else n_pass++;
            end
            tick();
        end
    endtask

    task automatic test_tie();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        bus.cpu_addr = 16'h1000;
        bus.aux_addr = 16'h2000;
        bus.aux_we   = 1'b0;
        bus.m_rdata  = 16'h1111;
        bus.cpu_rd   = 1'b1;
        bus.aux_req  = 1'b1;
        tick();
        n_total++; if (bus.m_addr !== 16'h1000) $display("FAIL tie1_m_addr got %h exp %h", bus.m_addr, 16'h1000); else n_pass++;
        n_total++; if (ctl !== 6'b110100) $display("FAIL tie1_ctl got %b exp %b", ctl, 6'b110100); else n_pass++;
        tick();
        tick();
        n_total++; if (ctl !== 6'b000110) $display("FAIL tie1_done got %b exp %b", ctl, 6'b000110); else n_pass++;
        n_total++; if (bus.cpu_rdata !== 16'h1111) $display("FAIL tie1_cpu_rdata got %h exp %h", bus.cpu_rdata, 16'h1111); else n_pass++;
        bus.cpu_rd  = 1'b0;
        bus.aux_req = 1'b0;
        tick();
        tick();
        bus.m_rdata = 16'h2222;
        bus.cpu_rd  = 1'b1;
        bus.aux_req = 1'b1;
        tick();
        n_total++; if (bus.m_addr !== 16'h2000) $display("FAIL tie2_m_addr got %h exp %h", bus.m_addr, 16'h2000); else n_pass++;
        n_total++; if (ctl !== 6'b110100) $display("FAIL tie2_ctl got %b exp %b", ctl, 6'b110100); else n_pass++;
        tick();
        tick();
        n_total++; if (ctl !== 6'b000101) $display("FAIL tie2_done got %b exp %b", ctl, 6'b000101); else n_pass++;
        n_total++; if (bus.aux_rdata !== 16'h2222) $display("FAIL tie2_aux_rdata got %h exp %h", bus.aux_rdata, 16'h2222); else n_pass++;
        n_total++; if (bus.cpu_rdata !== 16'h1111) $display("FAIL tie2_cpu_rdata got %h exp %h", bus.cpu_rdata, 16'h1111); else n_pass++;
        bus.m_rdata = 16'h3333;
        tick();
        n_total++; if (ctl !== 6'b000000) $display("FAIL tie2_idle got %b exp %b", ctl, 6'b000000); else n_pass++;
        tick();
        n_total++; if (bus.m_addr !== 16'h1000) $display("FAIL tie3_m_addr got %h exp %h", bus.m_addr, 16'h1000); else n_pass++;
        n_total++; if (ctl !== 6'b110100) $display("FAIL tie3_ctl got %b exp %b", ctl, 6'b110100); else n_pass++;
        tick();
        tick();
        n_total++; if (ctl !== 6'b000110) $display("FAIL tie3_done got %b exp %b", ctl, 6'b000110); else n_pass++;
        n_total++; if (bus.cpu_rdata !== 16'h3333) $display("FAIL tie3_cpu_rdata got %h exp %h", bus.cpu_rdata, 16'h3333); else n_pass++;
        n_total++; if (bus.aux_rdata !== 16'h2222) $display("FAIL tie3_aux_rdata got %h exp %h", bus.aux_rdata, 16'h2222); else n_pass++;
        bus.cpu_rd  = 1'b0;
        bus.aux_req = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_hold_request();
        int n_rdy;
        int n_ce;
        n_rdy = 0;
        n_ce  = 0;
        bus.cpu_addr = 16'h0042;
        bus.m_rdata  = 16'h4242;
        bus.cpu_rd   = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.cpu_ready) n_rdy++;
            if (bus.m_ce) n_ce++;
        end
        n_total++; if (n_rdy !== 1) $display("FAIL hold_ready_count got %0d exp %0d", n_rdy, 1); else n_pass++;
        n_total++; if (n_ce !== 2) $display("FAIL hold_ce_count got %0d exp %0d", n_ce, 2); else n_pass++;
        bus.cpu_rd = 1'b0;
        tick();
        bus.cpu_rd = 1'b1;
        n_rdy = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.cpu_ready) n_rdy++;
        end
        n_total++; if (n_rdy !== 1) $display("FAIL rearm_ready_count got %0d exp %0d", n_rdy, 1); else n_pass++;
        bus.cpu_rd = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset_mid_access();
        bus.cpu_addr = 16'h0077;
        bus.cpu_rd   = 1'b1;
        tick();
        n_total++; if (ctl !== 6'b110100) $display("FAIL rstmid_ctl got %b exp %b", ctl, 6'b110100); else n_pass++;
        tick();
        rst        = 1'b0;
        bus.cpu_rd = 1'b0;
        tick();
        n_total++; if (ctl !== 6'b000000) $display("FAIL rstmid_ctl_after got %b exp %b", ctl, 6'b000000); else n_pass++;
        n_total++; if (bus.m_addr !== 16'h0000) $display("FAIL rstmid_m_addr got %h exp %h", bus.m_addr, 16'h0000); else n_pass++;
        n_total++; if (bus.m_wdata !== 16'h0000) $display("FAIL rstmid_m_wdata got %h exp %h", bus.m_wdata, 16'h0000); else n_pass++;
        n_total++; if (bus.cpu_rdata !== 16'h0000) $display("FAIL rstmid_cpu_rdata got %h exp %h", bus.cpu_rdata, 16'h0000); else n_pass++;
        n_total++; if (bus.aux_rdata !== 16'h0000) $display("FAIL rstmid_aux_rdata got %h exp %h", bus.aux_rdata, 16'h0000); else n_pass++;
        rst = 1'b1;
        tick();
        n_total++; if (ctl !== 6'b000000) $display("FAIL rstmid_no_ready got %b exp %b", ctl, 6'b000000); else n_pass++;
        bus.cpu_addr = 16'h0099;
        bus.m_rdata  = 16'h9999;
        bus.cpu_rd   = 1'b1;
        tick();
        n_total++; if (bus.m_addr !== 16'h0099) $display("FAIL rstmid_next_addr got %h exp %h", bus.m_addr, 16'h0099); else n_pass++;
        n_total++; if (ctl !== 6'b110100) $display("FAIL rstmid_next_ctl got %b exp %b", ctl, 6'b110100); else n_pass++;
        bus.cpu_rd = 1'b0;
        tick();
        tick();
        n_total++; if (ctl !== 6'b000110) $display("FAIL rstmid_next_done got %b exp %b", ctl, 6'b000110); else n_pass++;
        n_total++; if (bus.cpu_rdata !== 16'h9999) $display("FAIL rstmid_next_rdata got %h exp %h", bus.cpu_rdata, 16'h9999); else n_pass++;
        tick();
        tick();
    endtask

    task automatic test_wait1_aux_read();
        bus1.aux_addr = 16'h00F0;
        bus1.aux_we   = 1'b0;
        bus1.m_rdata  = 16'hFFFF;
        bus1.aux_req  = 1'b1;
        tick();
        n_total++; if (ctl1 !== 6'b110100) $display("FAIL w1_access got %b exp %b", ctl1, 6'b110100); else n_pass++;
        n_total++; if (bus1.m_addr !== 16'h00F0) $display("FAIL w1_m_addr got %h exp %h", bus1.m_addr, 16'h00F0); else n_pass++;
        bus1.aux_req = 1'b0;
        tick();
        n_total++; if (ctl1 !== 6'b000101) $display("FAIL w1_done got %b exp %b", ctl1, 6'b000101); else n_pass++;
        n_total++; if (bus1.aux_rdata !== 16'hFFFF) $display("FAIL w1_aux_rdata got %h exp %h", bus1.aux_rdata, 16'hFFFF); else n_pass++;
        n_total++; if (bus1.cpu_rdata !== 16'h0000) $display("FAIL w1_cpu_rdata got %h exp %h", bus1.cpu_rdata, 16'h0000); else n_pass++;
        tick();
        n_total++; if (ctl1 !== 6'b000000) $display("FAIL w1_idle got %b exp %b", ctl1, 6'b000000); else n_pass++;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst     = 1'b0;
        bus.cpu_rd     = 1'b0;
        bus.cpu_wr     = 1'b0;
        bus.cpu_addr   = 16'h0000;
        bus.cpu_wdata  = 16'h0000;
        bus.aux_req    = 1'b0;
        bus.aux_we     = 1'b0;
        bus.aux_addr   = 16'h0000;
        bus.aux_wdata  = 16'h0000;
        bus.m_rdata    = 16'h0000;
        bus1.cpu_rd    = 1'b0;
        bus1.cpu_wr    = 1'b0;
        bus1.cpu_addr  = 16'h0000;
        bus1.cpu_wdata = 16'h0000;
        bus1.aux_req   = 1'b0;
        bus1.aux_we    = 1'b0;
        bus1.aux_addr  = 16'h0000;
        bus1.aux_wdata = 16'h0000;
        bus1.m_rdata   = 16'h0000;

        test_reset();
        test_cpu_read();
        test_cpu_write();
        test_tie();
        test_hold_request();
        test_reset_mid_access();
        test_wait1_aux_read();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one external single-port 16-bit SRAM between the CPU data port and one auxiliary requester (DMA/video). Sits between the cpu's ram_read/ram_write/e_addr_bus/e_data/e_mem_bus/e_mem_busy/e_mem_ready pins and the board SRAM pins. It arbitrates round-robin, sequences fixed-wait-state SRAM cycles and returns a per-port completion pulse.

## Interface
- WAIT_CYCLES, 2: SRAM access length in cycles; legal range 1..15.
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-low
- cpu_rd  in  1  CPU read request (ram_read)
- cpu_wr  in  1  CPU write request (ram_write)
- cpu_addr  in  16  CPU address (e_addr_bus)
- cpu_wdata  in  16  CPU write data (e_data)
- cpu_rdata  out  16  read data to CPU (e_mem_bus)
- cpu_busy  out  1  access in flight on either port (e_mem_busy)
- cpu_ready  out  1  one-cycle CPU completion pulse (e_mem_ready)
- aux_req  in  1  auxiliary request
- aux_we  in  1  auxiliary write when 1, read when 0
- aux_addr  in  16  auxiliary address
- aux_wdata  in  16  auxiliary write data
- aux_rdata  out  16  read data to auxiliary port
- aux_ack  out  1  one-cycle auxiliary completion pulse
- m_addr  out  16  SRAM address
- m_wdata  out  16  SRAM write data
- m_rdata  in  16  SRAM read data
- m_ce, m_oe, m_we  out  1 each  SRAM chip enable, output enable, write enable (active-high)

## Operation
- FSM states: IDLE, ACCESS, DONE. Reset (rst=0 at a clock edge) -> IDLE.
- Request valid: CPU = (cpu_rd|cpu_wr) & cpu_armed; aux = aux_req & aux_armed. Sampled only in IDLE.
- Grant in IDLE: single valid requester wins. If both are valid, the port not granted last wins. The last-grant flag resets to "aux", so CPU wins the first tie.
- On grant: latch address, write data and direction into m_addr/m_wdata/op registers. Load wait counter with WAIT_CYCLES-1. Go to ACCESS.
- CPU with cpu_rd and cpu_wr both high: treated as write.
- ACCESS: m_ce=1; m_oe=1 for read; m_we=1 for write. Counter decrements each cycle. At 0: read latches m_rdata into cpu_rdata or aux_rdata (granted port only), then -> DONE.
- DONE: m_ce/m_oe/m_we=0. Pulse cpu_ready or aux_ack for the granted port. Clear that port's armed flag. -> IDLE.
- Armed flag: set when its request input is seen low at an edge. This forbids re-issuing a request held high across ready/ack. A new access needs a low-then-high request.
- cpu_busy = (state != IDLE), registered from next-state; 1 in ACCESS and DONE regardless of port.
- m_addr/m_wdata hold last latched values in IDLE. Unselected port's rdata is never modified.

## Timing
- Reset values: cpu_rdata=0, aux_rdata=0, cpu_busy=0, cpu_ready=0, aux_ack=0, m_addr=0, m_wdata=0, m_ce=m_oe=m_we=0. Both ports armed. Last-grant flag = aux.
- Grant edge E (IDLE, request valid). ACCESS occupies cycles E+1..E+WAIT_CYCLES. DONE is cycle E+WAIT_CYCLES+1, with ready/ack high and read data valid that cycle. Earliest next grant at the edge ending cycle E+WAIT_CYCLES+2.
- Request-to-completion latency with free bus: WAIT_CYCLES+1 cycles after the grant edge. Back-to-back accesses: period WAIT_CYCLES+2 cycles.
- Requester holds address/data/direction until its grant edge only. Later changes are ignored.
- Request dropped during ACCESS: the access still completes and ready/ack still pulses.
- Reset mid-ACCESS/DONE: next cycle is IDLE, all outputs at reset values, no ready/ack pulse.

## Test plan
- Reset, then cpu_rd at 0x1234 with m_rdata=0xBEEF, WAIT_CYCLES=2:
  - m_ce/m_oe high exactly 2 cycles with m_addr=0x1234.
  - cpu_ready pulses 1 cycle later with cpu_rdata=0xBEEF.
  - cpu_busy high 3 cycles.
- cpu_wr 0x0010 data 0x00AA:
  - m_we high 2 cycles with m_wdata=0x00AA, m_oe=0.
  - cpu_ready pulses; cpu_rdata is unchanged.
- cpu_rd and aux_req asserted in the same cycle after reset:
  - CPU served first, then aux.
  - Repeat the tie: aux is served first (round-robin alternation).
- cpu_rd held high through cpu_ready: exactly one access occurs. Dropping it for 1 cycle, then re-asserting, starts a second access.
- rst=0 during the second ACCESS cycle: next cycle all outputs 0, no cpu_ready. A following request completes normally.
- WAIT_CYCLES=1, aux read 0xFFFF: m_oe high 1 cycle, aux_ack on the next cycle, aux_rdata=0xFFFF.
